// File: rtl/debounce_oneshot.sv
// debounce_oneshot: push-button conditioner for the multiplier's start/load keys.
// Synchronises a raw bouncing button, accepts a new level only after it has been
// stable for MAX_COUNT clk cycles, and emits a one-cycle strobe on each confirmed press.
//
// Optional feature (compile-time macro DEBOUNCE_RELEASE_PULSE_EN):
//   when defined, adds btn_release_pulse, a one-cycle strobe on each confirmed release.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   btn_in            raw asynchronous button level, 1 = pressed
//   btn_level         debounced level, 1 = pressed
//   btn_pulse         one-cycle strobe on the edge a press is confirmed
//   btn_release_pulse one-cycle strobe on the edge a release is confirmed (macro only)
//   busy              high while a level change is being qualified
module debounce_oneshot #(
    parameter real FREQUENCY = 50_000_000.0,
    parameter real DELAY     = 0.03
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    output logic btn_release_pulse,
`endif
    output logic busy
);

    // Rounded (not truncated) so e.g. 0.03 * 50e6 cannot land one cycle short.
    localparam int unsigned MAX_COUNT = int'(DELAY * FREQUENCY);
    localparam int unsigned DW        = $clog2(MAX_COUNT);
    localparam logic [DW-1:0] CNT_LAST = DW'(MAX_COUNT - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] count;
    logic          s1;
    logic          s2;

    // Synchroniser, qualification FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= RELEASED;
            count     <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
            busy      <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
            btn_release_pulse <= 1'b0;
`endif
        end else begin
            s1        <= btn_in;
            s2        <= s1;
            btn_pulse <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
            btn_release_pulse <= 1'b0;
`endif
            case (state)
                RELEASED: begin
                    if (s2) begin
                        state <= WAIT_PRESS;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (!s2) begin
                        // Bounce: fall back to the level that was stable on entry.
                        state <= RELEASED;
                        count <= '0;
                        busy  <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        state     <= PRESSED;
                        count     <= '0;
                        busy      <= 1'b0;
                        btn_level <= 1'b1;
                        btn_pulse <= 1'b1;
                    end else begin
                        count <= count + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= WAIT_RELEASE;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (s2) begin
                        // Returning to PRESSED is not a new press: no strobe.
                        state <= PRESSED;
                        count <= '0;
                        busy  <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        state     <= RELEASED;
                        count     <= '0;
                        busy      <= 1'b0;
                        btn_level <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
                        btn_release_pulse <= 1'b1;
`endif
                    end else begin
                        count <= count + DW'(1);
                    end
                end
                default: begin
                    state     <= RELEASED;
                    count     <= '0;
                    busy      <= 1'b0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_oneshot.sv
// Testbench for debounce_oneshot with MAX_COUNT = 10 (1 kHz clock, 10 ms stable time).
// Every cycle is compared against a window-based reference model: the raw button is
// delayed two edges, and the level flips on any edge where the last MAX_COUNT+1
// synchronised samples all differ from the current level.
module tb_debounce_oneshot;

    localparam real FREQ  = 1000.0;
    localparam real DLY   = 0.01;
    localparam int  MAXC  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level;
    logic btn_pulse;
    logic busy;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic btn_release_pulse;
`endif

    debounce_oneshot #(
        .FREQUENCY(FREQ),
        .DELAY    (DLY)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_in           (btn_in),
        .btn_level        (btn_level),
        .btn_pulse        (btn_pulse),
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        .btn_release_pulse(btn_release_pulse),
`endif
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit raw_q[$];
    bit win[$];
    bit m_level;
    bit m_pulse;
    bit m_busy;
    bit m_rel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q.delete();
        raw_q.push_back(1'b0);
        raw_q.push_back(1'b0);
        win.delete();
        for (int i = 0; i < MAXC + 1; i++) win.push_back(1'b0);
        m_level = 1'b0;
        m_pulse = 1'b0;
        m_busy  = 1'b0;
        m_rel   = 1'b0;
    endtask

    task automatic model_edge(input bit b);
        bit x;
        bit all_diff;
        raw_q.push_back(b);
        x = raw_q.pop_front();
        win.push_back(x);
        void'(win.pop_front());
        all_diff = 1'b1;
        foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
        m_pulse = all_diff && !m_level;
        m_rel   = all_diff && m_level;
        if (all_diff) m_level = !m_level;
        m_busy = (x != m_level);
    endtask

    // One clock: apply inputs, advance model on the edge, compare 1 time unit later.
    task automatic tick(input bit r, input bit b);
        rst    = r;
        btn_in = b;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(b);
        #1;
        check("btn_level", {31'b0, btn_level}, {31'b0, m_level});
        check("btn_pulse", {31'b0, btn_pulse}, {31'b0, m_pulse});
        check("busy",      {31'b0, busy},      {31'b0, m_busy});
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        check("btn_release_pulse", {31'b0, btn_release_pulse}, {31'b0, m_rel});
`endif
    endtask

    // Hold btn_in for n edges; report edge index (from 1) of first pulse / first level change.
    task automatic hold(input bit b, input int n, output int first_pulse,
                        output int first_change, output int npulse);
        logic lvl0;
        lvl0 = btn_level;
        first_pulse  = 0;
        first_change = 0;
        npulse       = 0;
        for (int e = 1; e <= n; e++) begin
            tick(1'b0, b);
            if (btn_pulse === 1'b1) begin
                npulse++;
                if (first_pulse == 0) first_pulse = e;
            end
            if (first_change == 0 && btn_level !== lvl0) first_change = e;
        end
    endtask

    initial begin
        int fp;
        int fc;
        int np;
        int seg;
        bit b;

        model_reset();

        // 1. Reset, then idle low.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        hold(1'b0, 20, fp, fc, np);
        check("idle_pulses", np, 0);
        check("idle_change", fc, 0);

        // 2. Clean press.
        hold(1'b1, 20, fp, fc, np);
        check("press_pulse_edge", fp, 13);
        check("press_level_edge", fc, 13);
        check("press_npulse", np, 1);

        // 5. Glitch while pressed.
        hold(1'b0, 5, fp, fc, np);
        check("glitch_change", fc, 0);
        hold(1'b1, 20, fp, fc, np);
        check("glitch_npulse", np, 0);
        check("glitch_level", {31'b0, btn_level}, 1);

        // 4. Clean release.
        hold(1'b0, 20, fp, fc, np);
        check("release_level_edge", fc, 13);
        check("release_npulse", np, 0);

        // 3. Bounce, then hold pressed.
        for (int s = 0; s < 4; s++) begin
            hold(((s % 2) == 0) ? 1'b1 : 1'b0, 3, fp, fc, np);
            check("bounce_npulse", np, 0);
        end
        hold(1'b1, 20, fp, fc, np);
        check("bounce_pulse_edge", fp, 13);
        check("bounce_npulse_hold", np, 1);

        // 6. Reset at count=6 during press qualification.
        hold(1'b0, 20, fp, fc, np);
        hold(1'b1, 9, fp, fc, np);
        check("pre_rst_npulse", np, 0);
        tick(1'b1, 1'b1);
        check("rst_level", {31'b0, btn_level}, 0);
        check("rst_busy",  {31'b0, busy}, 0);
        hold(1'b1, 20, fp, fc, np);
        check("rst_pulse_edge", fp, 13);
        check("rst_npulse", np, 1);

        // Randomised segments with occasional reset.
        b = 1'b0;
        for (int k = 0; k < 300; k++) begin
            b   = ~b;
            seg = $urandom_range(1, 25);
            for (int i = 0; i < seg; i++) begin
                tick(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
